// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers (addr_i[3:2]): 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved.
module uart_tx_peripheral #(
   parameter int FIFO_DEPTH      = 8,
   parameter int CLK_DIV_DEFAULT = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en_i,
   input  logic        wr_en_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        tx_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic [15:0]   r_div;

   // Serial engine state
   state_t        r_state;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit_idx;
   logic [15:0]   r_timer;
   logic [15:0]   r_div_lat;

   logic [1:0]    w_sel;
   logic          w_push_req;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_busy;
   logic          w_bit_end;
   logic [7:0]    w_rd_data;
   logic [31:0]   w_status;
   logic          w_unused;

   assign w_sel      = addr_i[3:2];
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_busy     = (r_state != IDLE);
   assign w_bit_end  = (r_timer == 16'd0);
   assign w_push_req = wr_en_i && (w_sel == 2'd0);
   // Full is judged before the edge, so a same-edge pop cannot rescue a push
   assign w_push     = w_push_req && !w_full;
   // The engine takes a byte when idle, or back-to-back at the end of a stop bit
   assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
   assign w_rd_data  = r_mem[r_rd_ptr];
   assign w_status   = {16'd0, 8'(r_count), 4'd0, r_ovf, w_empty, w_full, w_busy};
   assign w_unused   = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

   // FIFO data array (no reset needed; pointers define validity)
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_push_req && w_full)
            r_ovf <= 1'b1;
         else if (wr_en_i && (w_sel == 2'd1) && data_i[3])
            r_ovf <= 1'b0;
      end
   end

   // Baud divisor register, clamped so every bit lasts at least 2 clocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= 16'(CLK_DIV_DEFAULT);
      end else if (wr_en_i && (w_sel == 2'd2)) begin
         r_div <= (data_i[15:0] < 16'd2) ? 16'd2 : data_i[15:0];
      end
   end

   // Registered read port; holds its value between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_o <= '0;
      end else if (rd_en_i) begin
         case (w_sel)
            2'd1:    data_o <= w_status;
            2'd2:    data_o <= {16'd0, r_div};
            default: data_o <= '0;
         endcase
      end
   end

   // Bit-serial frame engine; divisor is latched per frame so mid-frame writes wait
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_timer   <= '0;
         r_div_lat <= '0;
         tx_o      <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_shift   <= w_rd_data;
                  r_div_lat <= r_div;
                  r_timer   <= r_div - 16'd1;
                  tx_o      <= 1'b0;
                  r_state   <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  tx_o      <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_bit_idx <= 3'd0;
                  r_timer   <= r_div_lat - 16'd1;
                  r_state   <= DATA;
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_timer <= r_div_lat - 16'd1;
                  if (r_bit_idx == 3'd7) begin
                     tx_o    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     tx_o      <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  if (w_pop) begin
                     r_shift   <= w_rd_data;
                     r_div_lat <= r_div;
                     r_timer   <= r_div - 16'd1;
                     tx_o      <= 1'b0;
                     r_state   <= START;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_timer <= r_timer - 16'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Directed bench for uart_tx_peripheral: register vector table plus frame sequences.
module tb_uart_tx_peripheral;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] data = '0;
   logic [31:0] rdata;
   logic        tx;
   logic [31:0] v;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_DIV = 32'h8, A_RSV = 32'hC;

   uart_tx_peripheral #(.FIFO_DEPTH(8), .CLK_DIV_DEFAULT(434)) dut (
      .clk(clk), .rst(rst), .rd_en_i(rd_en), .wr_en_i(wr_en),
      .addr_i(addr), .data_i(data), .data_o(rdata), .tx_o(tx)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // All bus tasks start at a negedge and return at the next negedge
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; data = d; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; addr = '0; data = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
      addr = a; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0; addr = '0;
      r = rdata;
   endtask

   // Checks tx every clock of one 8N1 frame; optional STATUS read at sample rd_at
   task automatic frame(input logic [7:0] b, input int div, input int start_idx,
                        input int rd_at, input logic [31:0] rd_exp);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int i = start_idx; i < 10*div; i++) begin
         chk("tx_bit", {31'd0, tx}, {31'd0, bits[i/div]});
         if (i == rd_at) begin addr = A_ST; rd_en = 1'b1; end
         @(negedge clk);
         if (i == rd_at) begin
            rd_en = 1'b0; addr = '0;
            chk("status_mid", rdata, rd_exp);
         end
      end
   endtask

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] a;
      logic [31:0] d;
      logic        do_chk;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [16];

   initial begin
      tbl[0]  = '{1'b0, 1'b1, A_ST,  32'h0,         1'b1, 32'h4};
      tbl[1]  = '{1'b0, 1'b1, A_DIV, 32'h0,         1'b1, 32'd434};
      tbl[2]  = '{1'b0, 1'b1, A_TX,  32'h0,         1'b1, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, A_RSV, 32'h0,         1'b1, 32'h0};
      tbl[4]  = '{1'b1, 1'b0, A_DIV, 32'h0,         1'b0, 32'h0};
      tbl[5]  = '{1'b0, 1'b1, A_DIV, 32'h0,         1'b1, 32'd2};
      tbl[6]  = '{1'b1, 1'b0, A_DIV, 32'h1,         1'b0, 32'h0};
      tbl[7]  = '{1'b0, 1'b1, A_DIV, 32'h0,         1'b1, 32'd2};
      tbl[8]  = '{1'b1, 1'b0, A_DIV, 32'hFFFF_0007, 1'b0, 32'h0};
      tbl[9]  = '{1'b0, 1'b1, A_DIV, 32'h0,         1'b1, 32'd7};
      tbl[10] = '{1'b1, 1'b1, A_DIV, 32'h4,         1'b1, 32'd7};
      tbl[11] = '{1'b0, 1'b1, A_DIV, 32'h0,         1'b1, 32'd4};
      tbl[12] = '{1'b1, 1'b0, A_RSV, 32'h1234,      1'b0, 32'h0};
      tbl[13] = '{1'b0, 1'b1, A_RSV, 32'h0,         1'b1, 32'h0};
      tbl[14] = '{1'b1, 1'b0, A_ST,  32'hFFFF_FFF7, 1'b0, 32'h0};
      tbl[15] = '{1'b0, 1'b1, A_ST,  32'h0,         1'b1, 32'h4};

      // Reset
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_data_o", rdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Register table
      foreach (tbl[k]) begin
         addr = tbl[k].a; data = tbl[k].d; wr_en = tbl[k].wr; rd_en = tbl[k].rd;
         @(negedge clk);
         wr_en = 1'b0; rd_en = 1'b0; addr = '0; data = '0;
         if (tbl[k].do_chk) chk($sformatf("vec%0d", k), rdata, tbl[k].exp);
         chk("vec_tx_idle", {31'd0, tx}, 32'd1);
      end

      // Single frame 0xA5 at div 4, busy sampled mid-frame
      bus_write(A_TX, 32'hA5);
      chk("tx_before_start", {31'd0, tx}, 32'd1);
      @(negedge clk);
      frame(8'hA5, 4, 0, 20, 32'h5);
      chk("a5_idle", {31'd0, tx}, 32'd1);
      bus_read(A_ST, v); chk("a5_status", v, 32'h4);

      // Back-to-back frames, no idle gap
      bus_write(A_TX, 32'h55);
      bus_write(A_TX, 32'h0F);
      frame(8'h55, 4, 0, 5, 32'h0101);
      frame(8'h0F, 4, 0, -1, 32'h0);
      chk("b2b_idle", {31'd0, tx}, 32'd1);
      bus_read(A_ST, v); chk("b2b_status", v, 32'h4);

      // Overflow: 10 writes, first pops on 2nd edge, 10th is dropped
      bus_write(A_DIV, 32'd100);
      for (int i = 0; i < 10; i++) bus_write(A_TX, 32'h10 + i);
      frame(8'h10, 100, 8, 8, 32'h080B);
      for (int i = 1; i < 9; i++) frame(8'(8'h10 + i), 100, 0, -1, 32'h0);
      chk("ovf_idle", {31'd0, tx}, 32'd1);
      bus_read(A_ST, v); chk("ovf_status", v, 32'hC);
      bus_write(A_ST, 32'h8);
      bus_read(A_ST, v); chk("ovf_clear", v, 32'h4);

      // Divisor change mid-frame applies to the next frame only
      bus_write(A_DIV, 32'd4);
      bus_write(A_TX, 32'hFF);
      @(negedge clk);
      fork
         begin
            frame(8'hFF, 4, 0, -1, 32'h0);
            frame(8'h00, 8, 0, -1, 32'h0);
         end
         begin
            repeat (12) @(negedge clk);
            bus_write(A_DIV, 32'd8);
            bus_write(A_TX, 32'h00);
         end
      join
      chk("div_idle", {31'd0, tx}, 32'd1);
      bus_read(A_DIV, v); chk("div_read", v, 32'd8);

      // Reset mid-frame
      bus_write(A_DIV, 32'd8);
      for (int i = 0; i < 3; i++) bus_write(A_TX, 32'h00);
      repeat (19) @(negedge clk);
      chk("pre_rst_tx", {31'd0, tx}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_async_tx", {31'd0, tx}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_hold_tx", {31'd0, tx}, 32'd1);
      end
      rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         chk("post_rst_tx", {31'd0, tx}, 32'd1);
      end
      bus_read(A_ST, v);  chk("post_rst_status", v, 32'h4);
      bus_read(A_DIV, v); chk("post_rst_div", v, 32'd434);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
